key_expansion_seq: RTL and testbench

Iterative AES key expander that turns a cipher key into the full round-key schedule consumed by the round-key addition stage. It computes one 32-bit schedule word per clock using four instances of the team's byte S-box, then holds the complete schedule on a packed output bus until the next start. It sits directly upstream of the round datapath, which indexes the schedule by round number.

---
 rtl/key_expansion_seq.sv | 134 +++++++++++++
 tb/tb_key_expansion_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES key schedule, one word per clock; define KEYEXP_ZEROIZE_EN to add a zeroize input
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p, s;
        p = '0;
        s = x;
        for (int k = 0; k < 8; k++) begin
            p = z[k] ? p ^ s : p;
            s = xt(s);
        end
        return p;
    endfunction

    logic [7:0] sq, inv;

    // inverse as a^254 by repeated squaring; zero maps to zero
    always_comb begin
        sq = a;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module key_expansion_seq #(
    parameter int NK = 8
) (
    input  logic          clk,
    input  logic          reset,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic          zeroize,
`endif
    input  logic          start,
    input  logic [255:0]  key,
    output logic [1919:0] w,
    output logic          busy,
    output logic          done
);
    localparam int NR = NK + 6;
    localparam int WT = 4 * (NR + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [59:0][31:0] w_q, w_d;
    logic [5:0]        i_q, i_d;
    logic [2:0]        m_q, m_d;
    logic [7:0]        rcon_q, rcon_d;
    logic              done_q, done_d;
    logic              clr;
    logic [31:0]       temp, sub_in, sub_out, temp_x;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef KEYEXP_ZEROIZE_EN
    assign clr = reset | zeroize;
`else
    assign clr = reset;
`endif

    assign temp   = w_q[i_q - 6'd1];
    assign sub_in = (m_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
    end

    assign temp_x = (m_q == 3'd0) ? sub_out ^ {rcon_q, 24'h0}
                  : (NK == 8 && m_q == 3'd4) ? sub_out : temp;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        m_d     = m_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                w_d = '0;
                for (int j = 0; j < NK; j++) w_d[j[5:0]] = key[255 - 32*j -: 32];
                i_d     = 6'(NK);
                m_d     = 3'd0;
                rcon_d  = 8'h01;
                state_d = RUN;
            end
        end else begin
            w_d[i_q] = w_q[i_q - 6'(NK)] ^ temp_x;
            i_d      = i_q + 6'd1;
            m_d      = (m_q == 3'(NK - 1)) ? 3'd0 : m_q + 3'd1;
            rcon_d   = (m_q == 3'd0) ? xtime(rcon_q) : rcon_q;
            if (i_q == 6'(WT - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            w_q     <= '0;
            i_q     <= '0;
            m_q     <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            i_q     <= i_d;
            m_q     <= m_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign w    = w_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: FIPS-197 key schedules for NK=4/6/8 with a done-driven scoreboard
module tb_key_expansion_seq;
    typedef struct {
        int          st;
        int          lat;
        int          wt;
        int          ia;
        logic [31:0] a;
        int          ib;
        logic [31:0] b;
        int          ic;
        logic [31:0] c;
    } exp_t;

    localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    st;
    logic [2:0]    zz;
    logic [255:0]  key [3];
    logic [1919:0] wv [3];
    logic [2:0]    busy, dn;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    exp_t          q0[$], q1[$], q2[$];
    exp_t          e4, e6, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_expansion_seq #(.NK(4)) u4 (
        .clk(clk), .reset(reset),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize(zz[0]),
`endif
        .start(st[0]), .key(key[0]), .w(wv[0]), .busy(busy[0]), .done(dn[0]));
    key_expansion_seq #(.NK(6)) u6 (
        .clk(clk), .reset(reset),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize(zz[1]),
`endif
        .start(st[1]), .key(key[1]), .w(wv[1]), .busy(busy[1]), .done(dn[1]));
    key_expansion_seq #(.NK(8)) u8 (
        .clk(clk), .reset(reset),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize(zz[2]),
`endif
        .start(st[2]), .key(key[2]), .w(wv[2]), .busy(busy[2]), .done(dn[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_run(input int id, input exp_t e);
        logic [1919:0] v;
        int nk;
        v  = wv[id];
        nk = 4 + 2 * id;
        chk($sformatf("nk%0d latency", nk), 64'(cyc - e.st), 64'(e.lat));
        chk($sformatf("nk%0d w[%0d]", nk, e.ia), 64'(v[32*e.ia +: 32]), 64'(e.a));
        chk($sformatf("nk%0d w[%0d]", nk, e.ib), 64'(v[32*e.ib +: 32]), 64'(e.b));
        chk($sformatf("nk%0d w[%0d]", nk, e.ic), 64'(v[32*e.ic +: 32]), 64'(e.c));
        if (e.wt < 60) chk($sformatf("nk%0d tail zero", nk), 64'((v >> (32*e.wt)) == '0), 64'd1);
    endtask

    always @(negedge clk) begin
        if (dn[0]) begin
            if (q0.size() != 0) check_run(0, q0.pop_front());
            else chk("nk4 unexpected done", 64'd1, 64'd0);
        end
        if (dn[1]) begin
            if (q1.size() != 0) check_run(1, q1.pop_front());
            else chk("nk6 unexpected done", 64'd1, 64'd0);
        end
        if (dn[2]) begin
            if (q2.size() != 0) check_run(2, q2.pop_front());
            else chk("nk8 unexpected done", 64'd1, 64'd0);
        end
    end

    task automatic push(input int id, input exp_t e);
        e.st = cyc;
        if (id == 0) q0.push_back(e);
        else if (id == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic run_start(input int id, input logic [255:0] k, input bit do_push, input exp_t e);
        @(negedge clk);
        key[id] = k;
        st[id]  = 1'b1;
        @(negedge clk);
        st[id]  = 1'b0;
        if (do_push) push(id, e);
    endtask

    task automatic wait_done(input int id);
        for (int n = 0; n < 100 && !dn[id]; n++) @(negedge clk);
        chk($sformatf("nk%0d done seen", 4 + 2 * id), 64'(dn[id]), 64'd1);
    endtask

    initial begin
        e4 = '{0, 40, 44, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 5, 32'h88542cb1};
        e6 = '{0, 46, 52, 6, 32'hfe0c91f7, 51, 32'h01002202, 0, 32'h8e73b0f7};
        e8 = '{0, 52, 60, 8, 32'h9ba35411, 59, 32'h706c631e, 12, 32'ha8b09c1a};
        reset = 1'b1;
        st = '0;
        zz = '0;
        for (int j = 0; j < 3; j++) key[j] = '0;
        repeat (2) @(negedge clk);
        chk("reset w", 64'(wv[2] == '0), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(dn), 64'd0);
        reset = 1'b0;
        run_start(0, K4, 1'b1, e4);
        run_start(1, K6, 1'b1, e6);
        run_start(2, K8, 1'b1, e8);
        repeat (18) @(negedge clk);
        chk("nk8 busy mid-run", 64'(busy[2]), 64'd1);
        key[2] = '1;
        st[2]  = 1'b1;
        @(negedge clk);
        st[2]  = 1'b0;
        wait_done(2);
        key[2] = K8;
        st[2]  = 1'b1;
        @(negedge clk);
        st[2]  = 1'b0;
        push(2, e8);
        chk("restart w[8..59] zero", 64'((wv[2] >> 256) == '0), 64'd1);
        chk("restart w[0]", 64'(wv[2][31:0]), 64'h603deb10);
        chk("restart busy", 64'(busy[2]), 64'd1);
        wait_done(2);
        run_start(2, K8, 1'b0, e8);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort w", 64'(wv[2] == '0), 64'd1);
        chk("abort busy", 64'(busy[2]), 64'd0);
        chk("abort done", 64'(dn[2]), 64'd0);
        repeat (70) @(negedge clk);
`ifdef KEYEXP_ZEROIZE_EN
        run_start(0, K4, 1'b1, e4);
        wait_done(0);
        @(negedge clk);
        zz[0] = 1'b1;
        @(negedge clk);
        zz[0] = 1'b0;
        chk("zeroize w", 64'(wv[0] == '0), 64'd1);
        zz[0]  = 1'b1;
        key[0] = K4;
        st[0]  = 1'b1;
        @(negedge clk);
        zz[0] = 1'b0;
        st[0] = 1'b0;
        chk("zeroize+start busy", 64'(busy[0]), 64'd0);
        chk("zeroize+start w", 64'(wv[0] == '0), 64'd1);
        repeat (50) @(negedge clk);
`endif
        chk("nk4 queue drained", 64'(q0.size()), 64'd0);
        chk("nk6 queue drained", 64'(q1.size()), 64'd0);
        chk("nk8 queue drained", 64'(q2.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
